// File: rtl/stage_ex.sv
// stage_ex: execute stage of the in-order RISC-V pipeline (ALU, addresses, branch/jump resolution).
// Define STAGE_EX_MUL_EN to build the iterative shift-add multiplier for ops 12..15.

module stage_ex (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [31:0] ex_imm,
    input  logic [3:0]  ex_alu_op,
    input  logic        ex_src_imm,
    input  logic        ex_src_pc,
    input  logic        ex_read,
    input  logic        ex_write,
    input  logic        ex_extend,
    input  logic [1:0]  ex_width,
    input  logic        ex_jmp,
    input  logic        ex_jalr,
    input  logic        ex_br,
    input  logic        ex_br_inv,
    input  logic [4:0]  ex_reg,
    input  logic        mem_stall,
    output logic        ex_stall,
    output logic        mem_valid,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_data0,
    output logic [31:0] mem_data1,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_extend,
    output logic [1:0]  mem_width,
    output logic        mem_jmp,
    output logic        mem_br,
    output logic        mem_br_inv,
    output logic [4:0]  wb_reg
);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_SLL    = 4'd2;
    localparam logic [3:0] OP_SLT    = 4'd3;
    localparam logic [3:0] OP_SLTU   = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_SRL    = 4'd6;
    localparam logic [3:0] OP_SRA    = 4'd7;
    localparam logic [3:0] OP_OR     = 4'd8;
    localparam logic [3:0] OP_AND    = 4'd9;

    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_pc_q, mem_pc_d;
    logic [31:0] mem_data0_q, mem_data0_d;
    logic [31:0] mem_data1_q, mem_data1_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_extend_q, mem_extend_d;
    logic [1:0]  mem_width_q, mem_width_d;
    logic        mem_jmp_q, mem_jmp_d;
    logic        mem_br_q, mem_br_d;
    logic        mem_br_inv_q, mem_br_inv_d;
    logic [4:0]  wb_reg_q, wb_reg_d;

    logic        advance;
    logic [31:0] op_a, op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        br_cond;
    logic [31:0] res_data0, res_data1;
    logic        load_en;
    logic [31:0] load_data0;

    assign advance = ~mem_valid_q | ~mem_stall;

    always_comb begin
        op_a  = ex_src_pc  ? ex_pc  : ex_rs1;
        op_b  = ex_src_imm ? ex_imm : ex_rs2;
        shamt = op_b[4:0];
        case (ex_alu_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {31'b0, op_a < op_b};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            default: alu_res = 32'd0;
        endcase
    end

    // Branch compares always use the register operands, independent of the A/B muxes.
    always_comb begin
        case (ex_alu_op)
            OP_XOR:  br_cond = (ex_rs1 == ex_rs2);
            OP_SLT:  br_cond = $signed(ex_rs1) < $signed(ex_rs2);
            OP_SLTU: br_cond = ex_rs1 < ex_rs2;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        if (ex_read | ex_write) begin
            res_data0 = ex_rs1 + ex_imm;
            res_data1 = ex_rs2;
        end else if (ex_br) begin
            res_data0 = {31'b0, br_cond};
            res_data1 = ex_pc + ex_imm;
        end else if (ex_jmp) begin
            res_data0 = ex_pc + 32'd4;
            res_data1 = ex_jalr ? ((ex_rs1 + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
        end else begin
            res_data0 = alu_res;
            res_data1 = op_b;
        end
    end

`ifdef STAGE_EX_MUL_EN
    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

    mul_state_t  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] prod_q, prod_d;
    logic        neg_q, neg_d;
    logic        hi_q, hi_d;

    logic        is_mul;
    logic        a_signed, b_signed;
    logic [63:0] prod_fix;

    assign is_mul   = (ex_alu_op[3:2] == 2'b11);
    assign a_signed = (ex_alu_op == 4'd13) | (ex_alu_op == 4'd14);
    assign b_signed = (ex_alu_op == 4'd13);
    assign prod_fix = neg_q ? (64'd0 - prod_q) : prod_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        case (state_q)
            MUL_IDLE: begin
                if (ex_valid & is_mul) begin
                    mcand_d  = {32'd0, (a_signed & op_a[31]) ? (32'd0 - op_a) : op_a};
                    mplier_d = (b_signed & op_b[31]) ? (32'd0 - op_b) : op_b;
                    prod_d   = 64'd0;
                    neg_d    = (a_signed & op_a[31]) ^ (b_signed & op_b[31]);
                    hi_d     = (ex_alu_op != 4'd12);
                    cnt_d    = 5'd0;
                    state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                prod_d   = prod_q + (mplier_q[0] ? mcand_q : 64'd0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                if (advance) begin
                    state_d = MUL_IDLE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= 5'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            prod_q   <= 64'd0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
        end
    end

    // The multiply bundle takes its non-data fields from the inputs decode is holding.
    always_comb begin
        load_en    = (state_q == MUL_DONE) | ((state_q == MUL_IDLE) & ex_valid & ~is_mul);
        load_data0 = (state_q == MUL_DONE) ? (hi_q ? prod_fix[63:32] : prod_fix[31:0]) : res_data0;
        ex_stall   = (ex_valid & ~advance)
                   | ((state_q != MUL_IDLE) & ~((state_q == MUL_DONE) & advance))
                   | ((state_q == MUL_IDLE) & ex_valid & is_mul);
    end
`else
    always_comb begin
        load_en    = ex_valid;
        load_data0 = res_data0;
        ex_stall   = ex_valid & ~advance;
    end
`endif

    always_comb begin
        mem_valid_d  = mem_valid_q;
        mem_pc_d     = mem_pc_q;
        mem_data0_d  = mem_data0_q;
        mem_data1_d  = mem_data1_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_extend_d = mem_extend_q;
        mem_width_d  = mem_width_q;
        mem_jmp_d    = mem_jmp_q;
        mem_br_d     = mem_br_q;
        mem_br_inv_d = mem_br_inv_q;
        wb_reg_d     = wb_reg_q;
        if (advance) begin
            mem_valid_d = 1'b0;
            if (load_en) begin
                mem_valid_d  = 1'b1;
                mem_pc_d     = ex_pc;
                mem_data0_d  = load_data0;
                mem_data1_d  = res_data1;
                mem_read_d   = ex_read;
                mem_write_d  = ex_write;
                mem_extend_d = ex_extend;
                mem_width_d  = ex_width;
                mem_jmp_d    = ex_jmp;
                mem_br_d     = ex_br;
                mem_br_inv_d = ex_br_inv;
                wb_reg_d     = ex_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q  <= 1'b0;
            mem_pc_q     <= 32'd0;
            mem_data0_q  <= 32'd0;
            mem_data1_q  <= 32'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_extend_q <= 1'b0;
            mem_width_q  <= 2'd0;
            mem_jmp_q    <= 1'b0;
            mem_br_q     <= 1'b0;
            mem_br_inv_q <= 1'b0;
            wb_reg_q     <= 5'd0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            mem_pc_q     <= mem_pc_d;
            mem_data0_q  <= mem_data0_d;
            mem_data1_q  <= mem_data1_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_extend_q <= mem_extend_d;
            mem_width_q  <= mem_width_d;
            mem_jmp_q    <= mem_jmp_d;
            mem_br_q     <= mem_br_d;
            mem_br_inv_q <= mem_br_inv_d;
            wb_reg_q     <= wb_reg_d;
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_pc     = mem_pc_q;
    assign mem_data0  = mem_data0_q;
    assign mem_data1  = mem_data1_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_extend = mem_extend_q;
    assign mem_width  = mem_width_q;
    assign mem_jmp    = mem_jmp_q;
    assign mem_br     = mem_br_q;
    assign mem_br_inv = mem_br_inv_q;
    assign wb_reg     = wb_reg_q;

endmodule
